// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one spi_master between the core control unit (port 0)
// and the boot/DMA loader (port 1). Grants are round-robin, one SPI transaction
// is in flight at a time, and a watchdog ends a stuck transaction with an error.
module spi_bus_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int TIMEOUT_W = 10
) (
    input  logic                clk_core_i,
    input  logic                rst_n_i,
    input  logic [1:0]          req_start_i,
    input  logic [2*ADDR_W-1:0] req_addr_i,
    input  logic [1:0]          req_rnw_i,
    input  logic [3:0]          req_nbytes_i,
    input  logic [2*DATA_W-1:0] req_wdata_i,
    output logic [1:0]          req_busy_o,
    output logic [1:0]          req_done_o,
    output logic [1:0]          req_err_o,
    output logic [2*DATA_W-1:0] req_rdata1_o,
    output logic [2*DATA_W-1:0] req_rdata2_o,
    output logic                m_start_o,
    output logic [ADDR_W-1:0]   m_addr_o,
    output logic                m_rnw_o,
    output logic [1:0]          m_nbytes_o,
    output logic [DATA_W-1:0]   m_wdata_o,
    input  logic [DATA_W-1:0]   m_rdata1_i,
    input  logic [DATA_W-1:0]   m_rdata2_i,
    input  logic                m_done_i,
    input  logic                m_busy_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    // Last value the watchdog may reach before the transaction is abandoned.
    localparam logic [TIMEOUT_W-1:0] TIMER_MAX = {TIMEOUT_W{1'b1}};

    state_t               state_q, state_d;
    logic [1:0]           pending_q, pending_d;
    logic [1:0]           pend_set, pend_clr;
    logic                 grant_q, grant_d;
    logic                 last_grant_q, last_grant_d;
    logic                 pick;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic                 err_q, err_d;
    logic                 m_start_d;
    logic [1:0]           done_d, err_out_d;
    logic                 capture;

    // A port is busy while it waits for a grant or owns the master.
    assign req_busy_o = pending_q | ({2{state_q != ST_IDLE}} & {grant_q, ~grant_q});

    // Starts from a busy port are dropped; a new start is legal once busy falls.
    assign pend_set = req_start_i & ~req_busy_o;

    // Single requester wins outright; a tie goes to the port not served last.
    assign pick = (pending_q == 2'b11) ? ~last_grant_q : pending_q[1];

    // The master always sees the granted requester's command fields.
    assign m_addr_o   = grant_q ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
    assign m_rnw_o    = req_rnw_i[grant_q];
    assign m_nbytes_o = grant_q ? req_nbytes_i[3:2] : req_nbytes_i[1:0];
    assign m_wdata_o  = grant_q ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        // NOTE: every signal gets a default here so no path through the case infers a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        err_d        = err_q;
        pend_clr     = 2'b00;
        m_start_d    = 1'b0;
        done_d       = 2'b00;
        err_out_d    = 2'b00;
        capture      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // After a timeout the master may still be running; hold off until it stops.
                if (pending_q != 2'b00 && !m_busy_i) begin
                    grant_d        = pick;
                    pend_clr[pick] = 1'b1;
                    state_d        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                m_start_d = 1'b1;
                timer_d   = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (m_done_i) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q + TIMEOUT_W'(1);
                    if (timer_d == TIMER_MAX) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_d[grant_q]    = 1'b1;
                err_out_d[grant_q] = err_q;
                err_d              = 1'b0;
                last_grant_d       = grant_q;
                state_d            = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        pending_d = (pending_q & ~pend_clr) | pend_set;
    end

    // State, registered pulses and per-port read data; reset abandons any transaction.
    always_ff @(posedge clk_core_i) begin
        if (!rst_n_i) begin
            // NOTE: the read-data registers are reset too, since requesters may read them before any done.
            state_q      <= ST_IDLE;
            pending_q    <= 2'b00;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            timer_q      <= '0;
            err_q        <= 1'b0;
            m_start_o    <= 1'b0;
            req_done_o   <= 2'b00;
            req_err_o    <= 2'b00;
            req_rdata1_o <= '0;
            req_rdata2_o <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            pending_q    <= pending_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            err_q        <= err_d;
            m_start_o    <= m_start_d;
            req_done_o   <= done_d;
            req_err_o    <= err_out_d;
            if (capture) begin
                if (grant_q) begin
                    req_rdata1_o[2*DATA_W-1:DATA_W] <= m_rdata1_i;
                    req_rdata2_o[2*DATA_W-1:DATA_W] <= m_rdata2_i;
                end else begin
                    req_rdata1_o[DATA_W-1:0] <= m_rdata1_i;
                    req_rdata2_o[DATA_W-1:0] <= m_rdata2_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: a behavioural spi_master answers
// each m_start_o, and scoreboard queues hold the expected master commands and
// per-port completions in the order they must appear.
`timescale 1ns/1ps
module tb_spi_bus_arbiter;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 8;
    localparam int TIMEOUT_W = 10;

    logic                clk_core_i = 1'b0;
    logic                rst_n_i;
    logic [1:0]          req_start_i;
    logic [2*ADDR_W-1:0] req_addr_i;
    logic [1:0]          req_rnw_i;
    logic [3:0]          req_nbytes_i;
    logic [2*DATA_W-1:0] req_wdata_i;
    logic [1:0]          req_busy_o;
    logic [1:0]          req_done_o;
    logic [1:0]          req_err_o;
    logic [2*DATA_W-1:0] req_rdata1_o;
    logic [2*DATA_W-1:0] req_rdata2_o;
    logic                m_start_o;
    logic [ADDR_W-1:0]   m_addr_o;
    logic                m_rnw_o;
    logic [1:0]          m_nbytes_o;
    logic [DATA_W-1:0]   m_wdata_o;
    logic [DATA_W-1:0]   m_rdata1_i;
    logic [DATA_W-1:0]   m_rdata2_i;
    logic                m_done_i;
    logic                m_busy_i;

    spi_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk_core_i  (clk_core_i),
        .rst_n_i     (rst_n_i),
        .req_start_i (req_start_i),
        .req_addr_i  (req_addr_i),
        .req_rnw_i   (req_rnw_i),
        .req_nbytes_i(req_nbytes_i),
        .req_wdata_i (req_wdata_i),
        .req_busy_o  (req_busy_o),
        .req_done_o  (req_done_o),
        .req_err_o   (req_err_o),
        .req_rdata1_o(req_rdata1_o),
        .req_rdata2_o(req_rdata2_o),
        .m_start_o   (m_start_o),
        .m_addr_o    (m_addr_o),
        .m_rnw_o     (m_rnw_o),
        .m_nbytes_o  (m_nbytes_o),
        .m_wdata_o   (m_wdata_o),
        .m_rdata1_i  (m_rdata1_i),
        .m_rdata2_i  (m_rdata2_i),
        .m_done_i    (m_done_i),
        .m_busy_i    (m_busy_i)
    );

    always #5 clk_core_i = ~clk_core_i;

    typedef struct {
        logic              port;
        logic [ADDR_W-1:0] addr;
        logic              rnw;
        logic [1:0]        nb;
        logic [DATA_W-1:0] wdata;
    } issue_t;

    typedef struct {
        logic              port;
        logic              err;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
    } done_t;

    typedef enum int {K_NORMAL, K_TIMEOUT, K_NO_DONE} kind_t;

    issue_t            issue_q[$];
    done_t             done_q[$];
    int                checks = 0;
    int                errors = 0;
    logic              mon_en = 1'b0;
    logic              hang   = 1'b0;
    logic [DATA_W-1:0] mdl_rd1[2];
    logic [DATA_W-1:0] mdl_rd2[2];

    // Read data the master model returns for a given address.
    function automatic logic [DATA_W-1:0] f_rd1(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'hB7;
    endfunction
    function automatic logic [DATA_W-1:0] f_rd2(input logic [ADDR_W-1:0] a);
        return ~a[7:0];
    endfunction

    // Behavioural spi_master: busy from start, done two cycles later (or never when hung).
    initial begin
        logic [ADDR_W-1:0] a;
        m_done_i = 1'b0; m_busy_i = 1'b0; m_rdata1_i = '0; m_rdata2_i = '0;
        forever begin
            @(negedge clk_core_i);
            if (m_start_o === 1'b1) begin
                a        = m_addr_o;
                m_busy_i = 1'b1;
                if (!hang) begin
                    repeat (2) @(negedge clk_core_i);
                    m_rdata1_i = f_rd1(a);
                    m_rdata2_i = f_rd2(a);
                    m_done_i   = 1'b1;
                    @(negedge clk_core_i);
                    m_done_i   = 1'b0;
                    m_busy_i   = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: compares every master start and every completion with the queues.
    initial begin
        issue_t        e;
        done_t         d;
        logic [1:0]    exp_done;
        logic [1:0]    exp_err;
        forever begin
            @(posedge clk_core_i); #1;
            if (mon_en) begin
                if (m_start_o !== 1'b0) begin
                    checks++;
                    if (issue_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_start: m_start_o=%b m_addr_o=%h, no start expected", m_start_o, m_addr_o);
                    end else begin
                        e = issue_q.pop_front();
                        if ({m_addr_o, m_rnw_o, m_nbytes_o, m_wdata_o} !== {e.addr, e.rnw, e.nb, e.wdata}) begin
                            errors++;
                            $display("FAIL issue_fields: got addr=%h rnw=%b nb=%0d wd=%h, want port%0d addr=%h rnw=%b nb=%0d wd=%h",
                                     m_addr_o, m_rnw_o, m_nbytes_o, m_wdata_o, e.port, e.addr, e.rnw, e.nb, e.wdata);
                        end
                    end
                end
                if (req_done_o !== 2'b00) begin
                    checks++;
                    if (done_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done: req_done_o=%b req_err_o=%b, no completion expected", req_done_o, req_err_o);
                    end else begin
                        d        = done_q.pop_front();
                        exp_done = d.port ? 2'b10 : 2'b01;
                        exp_err  = d.err ? exp_done : 2'b00;
                        if (req_done_o !== exp_done || req_err_o !== exp_err ||
                            req_rdata1_o[int'(d.port)*DATA_W +: DATA_W] !== d.rd1 ||
                            req_rdata2_o[int'(d.port)*DATA_W +: DATA_W] !== d.rd2) begin
                            errors++;
                            $display("FAIL done_fields: got done=%b err=%b rd1=%h rd2=%h, want done=%b err=%b rd1=%h rd2=%h",
                                     req_done_o, req_err_o, req_rdata1_o, req_rdata2_o, exp_done, exp_err, d.rd1, d.rd2);
                        end
                    end
                end else if (req_err_o !== 2'b00) begin
                    checks++;
                    errors++;
                    $display("FAIL err_without_done: req_err_o=%b, want 00", req_err_o);
                end
            end
        end
    end

    // Drive one requester's command and start bit, queueing what must follow.
    task automatic set_req(input int p, input logic [ADDR_W-1:0] addr, input logic rnw,
                           input logic [1:0] nb, input logic [DATA_W-1:0] wd, input kind_t kind);
        issue_t e;
        done_t  d;
        req_addr_i[p*ADDR_W +: ADDR_W]   = addr;
        req_rnw_i[p]                     = rnw;
        req_nbytes_i[p*2 +: 2]           = nb;
        req_wdata_i[p*DATA_W +: DATA_W]  = wd;
        req_start_i[p]                   = 1'b1;
        e = '{port: p[0], addr: addr, rnw: rnw, nb: nb, wdata: wd};
        issue_q.push_back(e);
        if (kind == K_NORMAL) begin
            mdl_rd1[p] = f_rd1(addr);
            mdl_rd2[p] = f_rd2(addr);
        end
        if (kind != K_NO_DONE) begin
            d = '{port: p[0], err: (kind == K_TIMEOUT), rd1: mdl_rd1[p], rd2: mdl_rd2[p]};
            done_q.push_back(d);
        end
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n = 0;
        while ((issue_q.size() != 0 || done_q.size() != 0) && n < max_cycles) begin
            @(negedge clk_core_i);
            n++;
        end
        checks++;
        if (issue_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d starts and %0d dones still outstanding after %0d cycles, want 0",
                     name, issue_q.size(), done_q.size(), max_cycles);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({m_start_o, req_busy_o, req_done_o, req_err_o, req_rdata1_o, req_rdata2_o} !== '0) begin
            errors++;
            $display("FAIL %s: start=%b busy=%b done=%b err=%b rd1=%h rd2=%h, want all 0",
                     name, m_start_o, req_busy_o, req_done_o, req_err_o, req_rdata1_o, req_rdata2_o);
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        req_start_i = '0; req_addr_i = '0; req_rnw_i = '0; req_nbytes_i = '0; req_wdata_i = '0;
        mdl_rd1 = '{default: '0};
        mdl_rd2 = '{default: '0};
        repeat (3) @(posedge clk_core_i);
        @(negedge clk_core_i);
        check_all_zero("reset_outputs");
        rst_n_i = 1'b1;
        mon_en  = 1'b1;
    endtask

    // Fresh from reset the tie goes to port 0, then port 1.
    task automatic test_both_same_cycle();
        @(negedge clk_core_i);
        set_req(0, 16'h0100, 1'b1, 2'd2, 8'h00, K_NORMAL);
        set_req(1, 16'h0101, 1'b0, 2'd1, 8'h77, K_NORMAL);
        @(negedge clk_core_i);
        req_start_i = '0;
        checks++;
        if (req_busy_o !== 2'b11) begin
            errors++;
            $display("FAIL both_busy: req_busy_o=%b, want 11", req_busy_o);
        end
        wait_drain("both_same_cycle", 100);
    endtask

    task automatic test_read_single();
        int n;
        @(negedge clk_core_i);
        set_req(0, 16'h0012, 1'b1, 2'd1, 8'h00, K_NORMAL);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_core_i);
            req_start_i = '0;
            checks++;
            if (m_start_o !== (c == 2)) begin
                errors++;
                $display("FAIL start_latency_c%0d: m_start_o=%b, want %b", c, m_start_o, (c == 2));
            end
        end
        checks++;
        if (m_addr_o !== 16'h0012) begin
            errors++;
            $display("FAIL single_addr: m_addr_o=%h, want 0012", m_addr_o);
        end
        n = 0;
        while (m_done_i !== 1'b1 && n < 20) begin
            @(posedge clk_core_i);
            n++;
        end
        @(negedge clk_core_i);
        checks++;
        if (req_done_o !== 2'b00) begin
            errors++;
            $display("FAIL done_latency_early: req_done_o=%b, want 00", req_done_o);
        end
        @(negedge clk_core_i);
        checks++;
        if (req_done_o !== 2'b01 || req_err_o !== 2'b00) begin
            errors++;
            $display("FAIL done_latency: req_done_o=%b req_err_o=%b, want 01/00", req_done_o, req_err_o);
        end
        wait_drain("read_single", 50);
        checks++;
        if (req_rdata1_o[7:0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_rdata1: req_rdata1_o[7:0]=%h, want a5", req_rdata1_o[7:0]);
        end
    endtask

    task automatic test_write_while_busy();
        @(negedge clk_core_i);
        set_req(0, 16'h0040, 1'b1, 2'd2, 8'h00, K_NORMAL);
        repeat (3) @(negedge clk_core_i);
        req_start_i = '0;
        set_req(1, 16'h0200, 1'b0, 2'd1, 8'h3C, K_NORMAL);
        @(negedge clk_core_i);
        req_start_i = '0;
        checks++;
        if (req_busy_o !== 2'b11) begin
            errors++;
            $display("FAIL write_wait_busy: req_busy_o=%b, want 11", req_busy_o);
        end
        wait_drain("write_while_busy", 100);
        checks++;
        if (req_rdata1_o[7:0] !== f_rd1(16'h0040) || req_rdata2_o[7:0] !== f_rd2(16'h0040)) begin
            errors++;
            $display("FAIL port0_rdata_kept: rd1=%h rd2=%h, want %h %h",
                     req_rdata1_o[7:0], req_rdata2_o[7:0], f_rd1(16'h0040), f_rd2(16'h0040));
        end
    endtask

    // Both ports restart on their own done; a duplicate start follows each real one.
    task automatic test_back_to_back();
        int   rounds[2];
        logic dup[2];
        rounds = '{1, 1};
        dup    = '{1'b1, 1'b1};
        @(negedge clk_core_i);
        set_req(0, 16'h1000, 1'b1, 2'd1, 8'h40, K_NORMAL);
        set_req(1, 16'h1001, 1'b1, 2'd1, 8'h40, K_NORMAL);
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk_core_i);
            req_start_i = '0;
            for (int p = 0; p < 2; p++) begin
                if (dup[p]) begin
                    req_start_i[p] = 1'b1;
                    dup[p] = 1'b0;
                end else if (req_done_o[p] === 1'b1 && rounds[p] < 8) begin
                    set_req(p, 16'h1000 + 16'(rounds[p] * 2 + p), rounds[p][0], 2'(rounds[p]),
                            8'h40 + 8'(rounds[p]), K_NORMAL);
                    rounds[p]++;
                    dup[p] = 1'b1;
                end
            end
            if (rounds[0] == 8 && rounds[1] == 8 && issue_q.size() == 0 && done_q.size() == 0)
                break;
        end
        req_start_i = '0;
        wait_drain("back_to_back", 100);
    endtask

    task automatic test_timeout();
        int n;
        int starts;
        hang = 1'b1;
        @(negedge clk_core_i);
        set_req(0, 16'h0300, 1'b1, 2'd1, 8'h00, K_TIMEOUT);
        repeat (3) @(negedge clk_core_i);
        req_start_i = '0;
        set_req(1, 16'h0301, 1'b1, 2'd1, 8'h00, K_NORMAL);
        @(negedge clk_core_i);
        req_start_i = '0;
        n = 0;
        while (done_q.size() > 1 && n < 1200) begin
            @(negedge clk_core_i);
            n++;
        end
        checks++;
        if (done_q.size() != 1) begin
            errors++;
            $display("FAIL timeout_done: no timed-out completion within 1200 cycles (outstanding %0d, want 1)", done_q.size());
        end
        starts = 0;
        repeat (20) begin
            @(negedge clk_core_i);
            if (m_start_o === 1'b1) starts++;
        end
        checks++;
        if (starts != 0) begin
            errors++;
            $display("FAIL held_while_master_busy: %0d starts, want 0", starts);
        end
        hang     = 1'b0;
        m_busy_i = 1'b0;
        wait_drain("timeout", 100);
    endtask

    task automatic test_reset_mid();
        hang = 1'b1;
        @(negedge clk_core_i);
        set_req(0, 16'h0400, 1'b1, 2'd1, 8'h00, K_NO_DONE);
        repeat (6) @(negedge clk_core_i);
        req_start_i = '0;
        rst_n_i  = 1'b0;
        hang     = 1'b0;
        m_busy_i = 1'b0;
        @(negedge clk_core_i);
        rst_n_i = 1'b1;
        mdl_rd1 = '{default: '0};
        mdl_rd2 = '{default: '0};
        check_all_zero("reset_mid_outputs");
        repeat (10) @(negedge clk_core_i);
        checks++;
        if (issue_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_issued: %0d starts outstanding, want 0", issue_q.size());
        end
        set_req(1, 16'h0555, 1'b1, 2'd2, 8'h00, K_NORMAL);
        @(negedge clk_core_i);
        req_start_i = '0;
        wait_drain("after_reset", 100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench still running at 2 ms, want finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_both_same_cycle();
        test_read_single();
        test_write_while_busy();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        repeat (5) @(negedge clk_core_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
